// File: rtl/fu_sequencer_if.sv
// rtl/fu_sequencer_if.sv - command and result handshake bundle for fu_sequencer
interface fu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3,
  parameter int CNT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_kind;
  logic [3:0]        cmd_sel;
  logic [AW-1:0]     cmd_rd;
  logic [AW-1:0]     cmd_ra;
  logic [AW-1:0]     cmd_rb;
  logic [CNT_W-1:0]  cmd_cnt;
  logic [DATA_W-1:0] cmd_imm;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_z;

  modport master (
    output cmd_valid, cmd_kind, cmd_sel, cmd_rd, cmd_ra, cmd_rb, cmd_cnt, cmd_imm, res_ready,
    input  cmd_ready, res_valid, res_data, res_z
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_sel, cmd_rd, cmd_ra, cmd_rb, cmd_cnt, cmd_imm, res_ready,
    output cmd_ready, res_valid, res_data, res_z
  );
endinterface

// File: rtl/fu_sequencer.sv
// rtl/fu_sequencer.sv - command sequencer with register file driving the ALU/shifter functional unit
module fu_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fu_sequencer_if.slave     bus,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [3:0]        fu_sel,
  input  logic [DATA_W-1:0] fu_f,
  input  logic              fu_z,
  output logic              busy
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     rd_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_z_q;

  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_z     = res_z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.cmd_valid) state_nxt = (bus.cmd_kind == 2'b00) ? EXEC : RESP;
      EXEC: if (cnt == '0) state_nxt = RESP;
      RESP: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at accept, so rd aliasing ra/rb cannot disturb an op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      fu_a        <= '0;
      fu_b        <= '0;
      fu_sel      <= '0;
      cnt         <= '0;
      rd_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_z_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_kind)
              2'b00: begin
                fu_a   <= regs[bus.cmd_ra];
                fu_b   <= regs[bus.cmd_rb];
                fu_sel <= bus.cmd_sel;
                cnt    <= bus.cmd_cnt;
                rd_q   <= bus.cmd_rd;
              end
              2'b01: begin
                regs[bus.cmd_rd] <= bus.cmd_imm;
                res_data_q       <= bus.cmd_imm;
                res_z_q          <= (bus.cmd_imm == '0);
                res_valid_q      <= 1'b1;
              end
              default: begin
                res_data_q  <= regs[bus.cmd_rb];
                res_z_q     <= (regs[bus.cmd_rb] == '0);
                res_valid_q <= 1'b1;
              end
            endcase
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            // Shifter results feed the B operand; ALU results feed A.
            if (fu_sel[3]) fu_b <= fu_f;
            else           fu_a <= fu_f;
          end else begin
            regs[rd_q]  <= fu_f;
            res_data_q  <= fu_f;
            res_z_q     <= fu_z;
            res_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fu_sequencer.sv
// tb/tb_fu_sequencer.sv - directed self-checking bench for fu_sequencer
module tb_fu_sequencer;
  logic        clk;
  logic        rst_n;
  logic [15:0] fu_a, fu_b, fu_f;
  logic [3:0]  fu_sel;
  logic        fu_z;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  int          lat;

  fu_sequencer_if #(.DATA_W(16), .AW(3), .CNT_W(4)) bus ();

  fu_sequencer #(.DATA_W(16), .NREGS(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .fu_a   (fu_a),
    .fu_b   (fu_b),
    .fu_sel (fu_sel),
    .fu_f   (fu_f),
    .fu_z   (fu_z),
    .busy   (busy)
  );

  // Functional unit stub: ALU adds, shifter doubles B.
  assign fu_f = fu_sel[3] ? (fu_b << 1) : (fu_a + fu_b);
  assign fu_z = (fu_f == 16'h0000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] kind, input logic [3:0] sel, input logic [2:0] rd,
                      input logic [2:0] ra, input logic [2:0] rb, input logic [3:0] cnt,
                      input logic [15:0] imm);
    chk("ready_before_send", bus.cmd_ready, 1);
    bus.cmd_kind  = kind;
    bus.cmd_sel   = sel;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_cnt   = cnt;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int l);
    l = 0;
    while (!bus.res_valid && l < 20) begin
      step();
      l++;
    end
    if (!bus.res_valid) l = -1;
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("idle_after_take", bus.cmd_ready, 1);
    chk("valid_low_after_take", bus.res_valid, 0);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] kind, input logic [3:0] sel,
                        input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [3:0] cnt, input logic [15:0] imm, input int exp_lat,
                        input logic [15:0] exp_data, input logic exp_z);
    int l;
    send(kind, sel, rd, ra, rb, cnt, imm);
    wait_res(l);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_data"}, bus.res_data, exp_data);
    chk({tag, "_z"}, bus.res_z, exp_z);
    take();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_kind  = '0;
    bus.cmd_sel   = '0;
    bus.cmd_rd    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_cnt   = '0;
    bus.cmd_imm   = '0;
    bus.res_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_fu_a", fu_a, 0);
    chk("rst_fu_b", fu_b, 0);
    chk("rst_fu_sel", fu_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_data", bus.res_data, 0);

    do_cmd("read_r5", 2'b10, 4'h0, 3'd0, 3'd0, 3'd5, 4'd0, 16'h0000, 0, 16'h0000, 1'b1);
    do_cmd("load_r1", 2'b01, 4'h0, 3'd1, 3'd0, 3'd0, 4'd9, 16'h0003, 0, 16'h0003, 1'b0);
    do_cmd("load_r2", 2'b01, 4'h0, 3'd2, 3'd0, 3'd0, 4'd0, 16'h0004, 0, 16'h0004, 1'b0);
    do_cmd("add_r3",  2'b00, 4'h0, 3'd3, 3'd1, 3'd2, 4'd0, 16'h0000, 1, 16'h0007, 1'b0);
    do_cmd("read_r3", 2'b11, 4'h0, 3'd0, 3'd0, 3'd3, 4'd0, 16'h0000, 0, 16'h0007, 1'b0);

    send(2'b00, 4'h0, 3'd4, 3'd1, 3'd2, 4'd3, 16'h0000);
    chk("rep_fu_a_0", fu_a, 16'h0003);
    chk("rep_fu_b_0", fu_b, 16'h0004);
    chk("rep_busy", busy, 1);
    step();
    chk("rep_fu_a_1", fu_a, 16'h0007);
    step();
    chk("rep_fu_a_2", fu_a, 16'h000B);
    step();
    chk("rep_fu_a_3", fu_a, 16'h000F);
    chk("rep_valid_early", bus.res_valid, 0);
    step();
    chk("rep_valid", bus.res_valid, 1);
    chk("rep_data", bus.res_data, 16'h0013);
    chk("rep_fu_b_held", fu_b, 16'h0004);
    take();
    do_cmd("read_r4", 2'b10, 4'h0, 3'd0, 3'd0, 3'd4, 4'd0, 16'h0000, 0, 16'h0013, 1'b0);

    do_cmd("shift_r5", 2'b00, 4'h8, 3'd5, 3'd0, 3'd1, 4'd2, 16'h0000, 3, 16'h0018, 1'b0);
    chk("shift_fu_a_held", fu_a, 16'h0000);
    chk("shift_fu_sel_held", fu_sel, 4'h8);

    do_cmd("load_r6", 2'b01, 4'h0, 3'd6, 3'd0, 3'd0, 4'd0, 16'hFFFF, 0, 16'hFFFF, 1'b0);
    do_cmd("load_r7", 2'b01, 4'h0, 3'd7, 3'd0, 3'd0, 4'd0, 16'h0001, 0, 16'h0001, 1'b0);
    do_cmd("wrap_r6", 2'b00, 4'h0, 3'd6, 3'd6, 3'd7, 4'd0, 16'h0000, 1, 16'h0000, 1'b1);
    do_cmd("read_r6", 2'b10, 4'h0, 3'd0, 3'd0, 3'd6, 4'd0, 16'h0000, 0, 16'h0000, 1'b1);

    send(2'b10, 4'h0, 3'd0, 3'd0, 3'd3, 4'd0, 16'h0000);
    bus.cmd_kind  = 2'b01;
    bus.cmd_rd    = 3'd0;
    bus.cmd_imm   = 16'hABCD;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_data", bus.res_data, 16'h0007);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      step();
    end
    bus.cmd_valid = 1'b0;
    take();
    do_cmd("read_r0", 2'b10, 4'h0, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0000, 0, 16'h0000, 1'b1);

    send(2'b00, 4'h0, 3'd4, 3'd1, 3'd2, 4'd5, 16'h0000);
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_fu_a", fu_a, 0);
    chk("arst_res_valid", bus.res_valid, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("arst_no_resp", bus.res_valid, 0);
    end
    do_cmd("read_r4_rst", 2'b10, 4'h0, 3'd0, 3'd0, 3'd4, 4'd0, 16'h0000, 0, 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fu_sequencer.md
Name: fu_sequencer

Overview:
Command-driven controller that sequences the 16-bit functional unit (ALU plus shifter, 4-bit select, zero flag). It owns an 8-entry register file and a small state machine. It accepts one command at a time over a valid/ready handshake, drives operands and select into the functional unit, and optionally iterates an operation with result feedback. It writes the result back and returns it over a second valid/ready handshake. It sits between the instruction-issue logic and the func_unit datapath.

Parameters:
DATA_W, 16, datapath width (must match functional unit).
NREGS, 8, register-file depth (address width 3).
CNT_W, 4, repeat-count width.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept command.
cmd_kind  input  2  00=FU op, 01=load immediate, 10=read register, 11=reserved (treated as 10).
cmd_sel  input  4  functional-unit select; bit3=1 selects shifter path.
cmd_rd  input  3  destination register.
cmd_ra  input  3  source A register.
cmd_rb  input  3  source B register (also read address for kind 10).
cmd_cnt  input  CNT_W  extra iterations; op executes cnt+1 times.
cmd_imm  input  16  immediate for kind 01.
res_valid  output  1  result available.
res_ready  input  1  consumer takes result.
res_data  output  16  result value.
res_z  output  1  zero flag of last FU evaluation (kind 00); 1 if data==0 otherwise.
fu_a  output  16  operand A to functional unit.
fu_b  output  16  operand B to functional unit.
fu_sel  output  4  select to functional unit.
fu_f  input  16  functional-unit result (combinational from fu_a/fu_b/fu_sel).
fu_z  input  1  functional-unit zero flag.
busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. cmd_ready = (state==IDLE); busy = !cmd_ready.
- Reset (async, rst_n low): state=IDLE; all 8 registers=0; fu_a=fu_b=0; fu_sel=0; res_valid=0; res_data=0; res_z=0; iteration counter=0. Reset mid-operation aborts: no writeback, no response.
- Accept edge: cmd_valid && cmd_ready at rising clk.
  - kind 00: fu_a<=R[ra], fu_b<=R[rb], fu_sel<=cmd_sel, counter<=cmd_cnt, latch rd; go EXEC.
  - kind 01: R[rd]<=imm, res_data<=imm, res_z<=(imm==0), res_valid<=1; go RESP.
  - kind 10/11: res_data<=R[rb], res_z<=(R[rb]==0), res_valid<=1; go RESP.
- EXEC, each edge:
  - if counter!=0: counter--, feed fu_f back into fu_a when fu_sel[3]==0, else into fu_b; the other operand is held.
  - if counter==0: R[rd]<=fu_f, res_data<=fu_f, res_z<=fu_z, res_valid<=1; go RESP.
- Latency: kind 00 spends cnt+1 cycles in EXEC; res_valid rises cnt+2 edges after the accept edge. Kinds 01/10 respond 1 edge after accept.
- RESP: res_valid, res_data and res_z are held stable until res_ready is sampled high. At that edge res_valid<=0 and state returns to IDLE. A new command is accepted no earlier than the following cycle: no same-cycle res/cmd overlap.
- fu_a, fu_b and fu_sel hold their last values outside EXEC.
- rd==ra or rd==rb is legal. Operands are captured at accept, so there is no hazard.
- cmd_cnt is ignored for kinds other than 00. Counter wrap is impossible: it only decrements to 0.
- cmd fields are sampled only on the accept edge. Changes at other times have no effect.

Test Plan:
Bench stub for functional unit: sel[3]=0 gives F=A+B; sel[3]=1 gives F=B<<1; Z=(F==0).
- Reset then idle -> cmd_ready=1, res_valid=0, fu_a=fu_b=0; read R5 -> res_data=0x0000, res_z=1.
- Load R1=0x0003, R2=0x0004; op sel=0000 rd=3 ra=1 rb=2 cnt=0 -> res_valid 2 edges after accept, res_data=0x0007, res_z=0; read R3 -> 0x0007.
- Repeat: op sel=0000 rd=4 ra=1 rb=2 cnt=3 -> 4 EXEC cycles, fu_a sequence 3,7,11,15, res_data=0x0013; shift sel=1000 rb=1 cnt=2 -> res_data=0x0018.
- Zero/wrap: load R6=0xFFFF, R7=0x0001, op rd=6 ra=6 rb=7 -> res_data=0x0000, res_z=1, R6=0.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid/res_data stable, cmd_ready=0, a command driven meanwhile is not accepted; release -> IDLE next cycle.
- Assert rst_n low during EXEC of cnt=5 op -> immediate IDLE, destination register reads 0, no response issued.
